// File: rtl/div_32b_seq_if.sv
// Start/done handshake bundle for the sequential 32-bit divider.
// The master issues operands; the slave (the divider) returns registered results.
interface div_32b_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_32b_seq.sv
// Unsigned 32-bit restoring divider: one quotient bit per clock, start/done handshake,
// results held in registers until the next operation completes.
module div_32b_seq (
    input  logic         clk,
    input  logic         rst,
    div_32b_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    // The partial remainder always stays below b, so its 33rd bit is never set and is not stored.
    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] b_reg;
    logic [5:0]  count;

    logic        busy_r;
    logic        done_r;
    logic [31:0] quot_r;
    logic [31:0] rem_r;
    logic        dbz_r;

    logic [32:0] r_sh;
    logic [32:0] trial;
    logic        borrow;
    logic [31:0] r_nxt;
    logic [31:0] q_nxt;

    // Trial subtraction at 33 bits: the borrow picks the quotient bit and whether to restore.
    always_comb begin
        r_sh   = {r, q[31]};
        trial  = r_sh - {1'b0, b_reg};
        borrow = trial[32];
        r_nxt  = borrow ? r_sh[31:0] : trial[31:0];
        q_nxt  = {q[30:0], ~borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            q      <= '0;
            b_reg  <= '0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        if (bus.b == 32'd0) begin
                            // Zero divisor resolves immediately without iterating.
                            state  <= DONE;
                            done_r <= 1'b1;
                            quot_r <= 32'hFFFF_FFFF;
                            rem_r  <= bus.a;
                            dbz_r  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                            r      <= '0;
                            q      <= bus.a;
                            b_reg  <= bus.b;
                            count  <= '0;
                            dbz_r  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state  <= DONE;
                        count  <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quot_r <= q_nxt;
                        rem_r  <= r_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_32b_seq.sv
// Bench for div_32b_seq: directed cases plus random operands checked against plain
// integer division, with handshake timing, reset and back-to-back behaviour.
module tb_div_32b_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_32b_seq_if bus ();
    div_32b_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;
    int  n;
    int  ndone;
    bit  got;
    logic [31:0] cap_q, cap_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic [31:0] av, input logic [31:0] bv);
        return (bv == 32'd0) ? 32'hFFFF_FFFF : av / bv;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] av, input logic [31:0] bv);
        return (bv == 32'd0) ? av : av % bv;
    endfunction

    // One operation: start for one cycle, scramble a/b afterwards, wait (bounded) for done.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int edges = 0;
        int busy_cyc = 0;
        bit overlap = 0;
        bit seen = 0;
        logic [31:0] mid_q = prev_q;
        logic [31:0] mid_r = prev_r;
        logic [31:0] eq = ref_q(av, bv);
        logic [31:0] er = ref_r(av, bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            bus.start = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            if (bus.busy) busy_cyc++;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (edges == 10) begin
                mid_q = bus.quotient;
                mid_r = bus.remainder;
            end
            if (bus.done) seen = 1'b1;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, edges, (bv == 0) ? 32'd1 : 32'd33);
        chk({tag, " busy_cycles"}, busy_cyc, (bv == 0) ? 32'd0 : 32'd32);
        chk({tag, " busy_and_done"}, 32'(overlap), 32'd0);
        chk({tag, " quotient"}, bus.quotient, eq);
        chk({tag, " remainder"}, bus.remainder, er);
        chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), (bv == 0) ? 32'd1 : 32'd0);
        if (bv != 0) begin
            chk({tag, " held_q_in_run"}, mid_q, prev_q);
            chk({tag, " held_r_in_run"}, mid_r, prev_r);
        end
        @(posedge clk);
        #1;
        chk({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
        chk({tag, " q_hold_idle"}, bus.quotient, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("100/7", 32'd100, 32'd7);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1);
        run_op("5/9", 32'd5, 32'd9);
        run_op("8000/ffff", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("1234/0", 32'd1234, 32'd0);
        run_op("7/7", 32'd7, 32'd7);

        // Start pulse with different operands in mid-RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd50;
        bus.b = 32'd5;
        ndone = 0;
        cap_q = '0;
        cap_r = '1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                cap_q = bus.quotient;
                cap_r = bus.remainder;
            end
            bus.start = (i == 5);
            bus.a = (i == 5) ? 32'd9 : $urandom;
            bus.b = (i == 5) ? 32'd2 : $urandom;
        end
        bus.start = 1'b0;
        chk("ignore_start done_count", ndone, 32'd1);
        chk("ignore_start quotient", cap_q, 32'd10);
        chk("ignore_start remainder", cap_r, 32'd0);
        prev_q = 32'd10;
        prev_r = 32'd0;

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(bus.busy), 32'd0);
        chk("async_rst done", 32'(bus.done), 32'd0);
        chk("async_rst quotient", bus.quotient, 32'd0);
        chk("async_rst remainder", bus.remainder, 32'd0);
        chk("async_rst dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("after_rst no_stray_done", 32'(bus.done), 32'd0);
        chk("after_rst idle_not_busy", 32'(bus.busy), 32'd0);
        prev_q = '0;
        prev_r = '0;
        run_op("1000/3", 32'd1000, 32'd3);

        // Start held high through the done cycle: the next operation starts at that edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd81;
        bus.b = 32'd9;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 45 && !got; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        chk("b2b first latency", n, 32'd33);
        chk("b2b first quotient", bus.quotient, 32'd9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b accepted busy", 32'(bus.busy), 32'd1);
        chk("b2b accepted done", 32'(bus.done), 32'd0);
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 45 && !got; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        chk("b2b second latency", n, 32'd32);
        chk("b2b second quotient", bus.quotient, 32'd9);
        chk("b2b second remainder", bus.remainder, 32'd0);
        prev_q = 32'd9;
        prev_r = 32'd0;

        // Random operands, with small divisors and zero mixed in.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case (k % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 255);
                2: rb = ra >> $urandom_range(0, 31);
                default: rb = (k == 7) ? 32'd0 : $urandom_range(1, 65535);
            endcase
            run_op($sformatf("rand%0d", k), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
